// File: rtl/ahb_uart_tx_if.sv
// Bus-side connection between the ahb_lite decoder and the UART transmitter.
// The decoder drives select/write/address/data; the UART returns read data.
interface ahb_uart_tx_if;
    logic        HSEL;
    logic        HWRITE;
    logic [3:0]  HADDR;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;

    modport master (output HSEL, output HWRITE, output HADDR, output HWDATA, input HRDATA);
    modport slave  (input HSEL, input HWRITE, input HADDR, input HWDATA, output HRDATA);
endinterface

// File: rtl/ahb_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO, a slave of the ahb_lite decoder.
// Latency: a DATA write while idle with EN set drives the start bit on the 2nd clock after the write edge.
// Backpressure: none on the bus; a byte written to a full FIFO is dropped and flagged in STATUS.OVR.
module ahb_uart_tx #(
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic         clk,
    input  logic         reset,
    ahb_uart_tx_if.slave bus,
    output logic         tx,
    output logic         irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [CW-1:0] count;
    logic [15:0]   bauddiv, bcnt;
    logic          en, ie, ovr;
    logic [7:0]    shreg;
    logic [2:0]    idx;
    state_t        state, state_nxt;
    logic          pop, push, push_req, wr, full, empty, tick;
    logic [1:0]    addr;
    logic [4:0]    count5;
    logic          unused_bits;

    assign wr       = bus.HSEL & bus.HWRITE;
    assign addr     = bus.HADDR[3:2];
    assign push_req = wr && (addr == 2'd0);
    assign full     = (count == CW'(FIFO_DEPTH));
    assign empty    = (count == '0);
    // A push at full still lands when the serializer pops in the same cycle.
    assign push     = push_req && (!full || pop);
    assign tick     = (bcnt == 16'd0);
    assign count5   = 5'(count);
    assign unused_bits = ^{bus.HADDR[1:0], bus.HWDATA[31:16]};

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= bus.HWDATA[7:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bauddiv <= DEFAULT_DIV;
            en      <= 1'b0;
            ie      <= 1'b0;
            ovr     <= 1'b0;
        end else begin
            if (push_req && !push)
                ovr <= 1'b1;
            else if (wr && addr == 2'd3 && bus.HWDATA[2])
                ovr <= 1'b0;
            // Divisors below 2 cannot time a bit, so they are clamped.
            if (wr && addr == 2'd2)
                bauddiv <= (bus.HWDATA[15:1] == 15'd0) ? 16'd2 : bus.HWDATA[15:0];
            if (wr && addr == 2'd3) begin
                en <= bus.HWDATA[0];
                ie <= bus.HWDATA[1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (en && !empty) begin
                    pop       = 1'b1;
                    state_nxt = START;
                end
            end
            START: if (tick) state_nxt = DATA;
            DATA:  if (tick && idx == 3'd7) state_nxt = STOP;
            STOP: begin
                if (tick) begin
                    if (en && !empty) begin
                        pop       = 1'b1;
                        state_nxt = START;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // bcnt reloads from the live BAUDDIV, so a new divisor applies at the next bit boundary.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bcnt  <= '0;
            idx   <= '0;
            shreg <= '0;
        end else if (pop) begin
            shreg <= mem[rptr];
            bcnt  <= bauddiv - 16'd1;
            idx   <= '0;
        end else if (state != IDLE) begin
            if (tick) begin
                bcnt <= bauddiv - 16'd1;
                if (state == DATA) idx <= idx + 3'd1;
            end else begin
                bcnt <= bcnt - 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx  <= 1'b1;
            irq <= 1'b0;
        end else begin
            tx  <= (state == DATA) ? shreg[idx] : (state != START);
            irq <= ie && empty && (state == IDLE);
        end
    end

    always_comb begin
        bus.HRDATA = '0;
        case (addr)
            2'd1:    bus.HRDATA = {23'd0, count5, ovr, empty, full, state != IDLE};
            2'd2:    bus.HRDATA = {16'd0, bauddiv};
            2'd3:    bus.HRDATA = {30'd0, ie, en};
            default: bus.HRDATA = '0;
        endcase
    end
endmodule

// File: tb/tb_ahb_uart_tx.sv
// Directed bench: register reads are checked inline, serial frames are decoded by a
// monitor and matched against a queue of expected bytes filled by the stimulus.
module tb_ahb_uart_tx;
    logic clk = 1'b0;
    logic reset;
    logic tx, irq;

    ahb_uart_tx_if bus();

    ahb_uart_tx #(.FIFO_DEPTH(4), .DEFAULT_DIV(16'd434)) dut (
        .clk(clk), .reset(reset), .bus(bus), .tx(tx), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        bit         b2b;
    } frame_t;

    frame_t exp_q[$];
    int vectors = 0;
    int errors  = 0;
    int mon_div = 4;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic expect_frame(input logic [7:0] d, input bit b2b);
        frame_t f;
        f.data = d;
        f.b2b  = b2b;
        exp_q.push_back(f);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.HSEL = 1'b1; bus.HWRITE = 1'b1; bus.HADDR = {a, 2'b00}; bus.HWDATA = d;
        @(posedge clk);
        #1;
        bus.HSEL = 1'b0; bus.HWRITE = 1'b0; bus.HWDATA = '0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.HSEL = 1'b1; bus.HWRITE = 1'b0; bus.HADDR = {a, 2'b00};
        #1;
        d = bus.HRDATA;
        bus.HSEL = 1'b0;
    endtask

    // Frame monitor: samples tx every falling edge, requires each bit to be steady for div cycles.
    initial begin
        int idle;
        idle = 0;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && tx === 1'b0) begin
                int div;
                logic [7:0] got;
                logic v;
                bit ok, abort, gap_ok;
                frame_t e;
                div = mon_div; ok = 1'b1; abort = 1'b0; got = '0; v = 1'b0;
                for (int b = 0; b < 10; b++) begin
                    for (int c = 0; c < div; c++) begin
                        if (b != 0 || c != 0) @(negedge clk);
                        if (reset !== 1'b1) abort = 1'b1;
                        if (c == 0) v = tx;
                        else if (tx !== v) ok = 1'b0;
                    end
                    if (b == 0) begin
                        if (v !== 1'b0) ok = 1'b0;
                    end else if (b == 9) begin
                        if (v !== 1'b1) ok = 1'b0;
                    end else begin
                        got[b-1] = v;
                    end
                end
                if (!abort) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        errors++;
                        $display("FAIL frame: unexpected byte 0x%0h on tx, none expected", got);
                    end else begin
                        e = exp_q.pop_front();
                        gap_ok = !e.b2b || (idle == 0);
                        check("frame {ok,gap_ok,byte}", {22'd0, ok, gap_ok, got},
                              {22'd0, 1'b1, 1'b1, e.data});
                    end
                end
                idle = 0;
            end else begin
                idle++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] r;
        bit acc;
        reset = 1'b0;
        bus.HSEL = 1'b0; bus.HWRITE = 1'b0; bus.HADDR = '0; bus.HWDATA = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_irq", 32'(irq), 32'd0);
        reset = 1'b1;
        bus_read(2'd1, r); check("reset_status", r, 32'h004);
        bus_read(2'd2, r); check("reset_bauddiv", r, 32'd434);
        bus_read(2'd3, r); check("reset_ctrl", r, 32'd0);

        // Single frame 0xA5 at DIV=4, busy throughout
        mon_div = 4;
        bus_write(2'd2, 32'd4);
        bus_write(2'd3, 32'd1);
        expect_frame(8'hA5, 1'b0);
        bus_write(2'd0, 32'hA5);
        @(posedge clk);
        acc = 1'b1;
        for (int i = 0; i < 40; i++) begin
            bus_read(2'd1, r);
            acc &= r[0];
        end
        check("busy_whole_frame", 32'(acc), 32'd1);
        repeat (6) @(negedge clk);
        bus_read(2'd1, r); check("status_after_a5", r, 32'h004);
        bus_read(2'd2, r); check("bauddiv_4", r, 32'd4);

        // Overflow with EN=0, then back-to-back drain
        bus_write(2'd3, 32'd0);
        for (int i = 0; i < 5; i++) bus_write(2'd0, 32'h11 * (i + 1));
        bus_read(2'd1, r); check("status_full_ovr", r, 32'h04A);
        expect_frame(8'h11, 1'b0);
        expect_frame(8'h22, 1'b1);
        expect_frame(8'h33, 1'b1);
        expect_frame(8'h44, 1'b1);
        bus_write(2'd3, 32'd1);
        repeat (175) @(negedge clk);
        bus_read(2'd1, r); check("status_drained_ovr", r, 32'h00C);

        // OVR clear, then push at full coinciding with a pop
        bus_write(2'd3, 32'h4);
        bus_read(2'd1, r); check("status_ovr_cleared", r, 32'h004);
        bus_read(2'd3, r); check("ctrl_after_clear", r, 32'd0);
        for (int i = 0; i < 4; i++) begin
            expect_frame(8'h61 + 8'(i), i != 0);
            bus_write(2'd0, 32'h61 + i);
        end
        expect_frame(8'h65, 1'b1);
        bus_write(2'd3, 32'd1);
        bus_write(2'd0, 32'h65);
        bus_read(2'd1, r); check("status_push_pop_full", r, 32'h043);
        repeat (215) @(negedge clk);
        bus_read(2'd1, r); check("status_after_five", r, 32'h004);

        // Divisor clamp and irq timing at DIV=2
        bus_write(2'd2, 32'd1);
        bus_read(2'd2, r); check("bauddiv_clamp_1", r, 32'd2);
        bus_write(2'd2, 32'd0);
        bus_read(2'd2, r); check("bauddiv_clamp_0", r, 32'd2);
        mon_div = 2;
        bus_write(2'd3, 32'd3);
        @(posedge clk);
        @(negedge clk);
        check("irq_idle_empty", 32'(irq), 32'd1);
        expect_frame(8'h00, 1'b0);
        bus_write(2'd0, 32'h00);
        @(posedge clk);
        acc = 1'b0;
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            acc |= irq;
        end
        check("irq_during_frame", 32'(acc), 32'd0);
        @(negedge clk);
        check("irq_after_stop", 32'(irq), 32'd1);
        repeat (5) @(negedge clk);

        // Reset during DATA bit 3
        bus_write(2'd3, 32'd1);
        bus_write(2'd0, 32'h00);
        bus_write(2'd0, 32'h77);
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("tx_data_bit3", 32'(tx), 32'd0);
        reset = 1'b0;
        #1;
        check("tx_async_reset", 32'(tx), 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        bus_read(2'd1, r); check("status_after_reset", r, 32'h004);
        bus_read(2'd3, r); check("ctrl_after_reset", r, 32'd0);
        bus_read(2'd2, r); check("bauddiv_after_reset", r, 32'd434);

        repeat (30) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
